// File: rtl/dpsk_mod_gen.sv
// Differential PSK modulator core: internal PRBS or external handshaked bit source,
// DBPSK/DQPSK differential phase encoding, phase held for SPS clocks per symbol.
module dpsk_mod_gen #(
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] TAPS   = 7'h60,
  parameter logic [LFSR_W-1:0] SEED   = 7'h01,
  parameter int                SPS    = 4,
  parameter int                MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              src_sel,
  input  logic              enable,
  input  logic [1:0]        ext_data,
  input  logic              ext_valid,
  output logic              ext_ready,
  output logic [1:0]        phase_out,
  output logic              xor_result,
  output logic              sym_strobe,
  output logic              busy,
  output logic              underrun
);

  localparam bit                QPSK       = (MODE != 0);
  localparam int                CNT_W      = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [LFSR_W-1:0] lfsr_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              src_sel_p0;

  logic              boundary;
  logic              sym_fire;
  logic [LFSR_W-1:0] lfsr_s1;
  logic [LFSR_W-1:0] lfsr_s2;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [1:0]        int_bits;
  logic [1:0]        ext_bits;
  logic [1:0]        sym_bits;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAPS)};
  endfunction

  // Differential increment in quarter turns; DQPSK uses Gray order so adjacent
  // phases differ in one bit.
  function automatic logic [1:0] phase_inc(input logic [1:0] bits);
    if (!QPSK) begin
      return bits[0] ? 2'd2 : 2'd0;
    end
    case (bits)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [LFSR_W-1:0] load_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? SEED : s;
  endfunction

  // DQPSK consumes two LFSR steps in one cycle: b1 from the first, b0 from the second.
  always_comb begin
    lfsr_s1  = lfsr_next(lfsr_p0);
    lfsr_s2  = lfsr_next(lfsr_s1);
    lfsr_adv = QPSK ? lfsr_s2 : lfsr_s1;
    int_bits = QPSK ? {lfsr_p0[LFSR_W-1], lfsr_s1[LFSR_W-1]} : {1'b0, lfsr_p0[LFSR_W-1]};
    ext_bits = QPSK ? ext_data : {1'b0, ext_data[0]};
    sym_bits = src_sel_p0 ? ext_bits : int_bits;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    boundary   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
        boundary   = enable && (cnt_p0 == '0);
      end
      default: state_next = IDLE;
    endcase
    ext_ready = boundary && src_sel_p0;
    sym_fire  = boundary && (!src_sel_p0 || ext_valid);
  end

  // ---- symbol stage: load has priority over enable and any boundary ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_p0    <= SEED;
      cnt_p0     <= '0;
      src_sel_p0 <= 1'b0;
      phase_out  <= 2'd0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else if (load) begin
      lfsr_p0    <= load_seed(seed_in);
      cnt_p0     <= '0;
      src_sel_p0 <= src_sel;
      phase_out  <= 2'd0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else if (boundary) begin
      cnt_p0 <= CNT_RELOAD;
      if (sym_fire) begin
        phase_out  <= phase_out + phase_inc(sym_bits);
        sym_strobe <= 1'b1;
        if (!src_sel_p0) begin
          lfsr_p0 <= lfsr_adv;
        end
      end else begin
        // Starved external slot: hold phase, flag it, keep symbol timing.
        sym_strobe <= 1'b0;
        underrun   <= 1'b1;
      end
    end else begin
      sym_strobe <= 1'b0;
      if (state == RUN && enable) begin
        cnt_p0 <= cnt_p0 - CNT_ONE;
      end
    end
  end

  assign xor_result = phase_out[1];
  assign busy       = (state == RUN);

endmodule

// File: doc/dpsk_mod_gen.md
# dpsk_mod_gen

Parametrised differential PSK modulator core, the next generation of the team's single-mode DPSK modulator. It carries an internal PRBS source (configurable LFSR) or an external bit stream with a valid/ready handshake. It differentially encodes symbols in DBPSK or DQPSK mode and holds each phase for a programmable number of clocks per symbol. The core sits between the data source and the phase-to-carrier mapper, and drives a 2-bit absolute phase index.

## Interface

- LFSR_W, 7: LFSR width (≥3).
- TAPS, 7'h60: feedback mask. feedback = XOR of (lfsr & TAPS). The default gives lfsr[6]^lfsr[5].
- SEED, 7'h01: fallback seed, used when seed_in is zero.
- SPS, 4: clocks per symbol (≥1).
- MODE, 0: 0 = DBPSK (1 bit/symbol), 1 = DQPSK (2 bits/symbol).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- load  in  1  one-cycle start/restart pulse.
- seed_in  in  LFSR_W  seed, sampled on load.
- src_sel  in  1  0 = internal LFSR, 1 = external stream. Sampled on load.
- enable  in  1  0 freezes all state; outputs hold.
- ext_data  in  2  external bits. DQPSK uses {b1,b0}; DBPSK uses bit 0.
- ext_valid  in  1  external data valid.
- ext_ready  out  1  core accepts ext_data this cycle.
- phase_out  out  2  absolute phase in quarter turns (0..3).
- xor_result  out  1  differentially encoded bit, phase_out[1].
- sym_strobe  out  1  one-cycle pulse when phase_out takes a new symbol.
- busy  out  1  state == RUN.
- underrun  out  1  sticky: an external symbol slot passed with no valid data.

## Operation

- States are IDLE and RUN. Reset (rst=0 at an edge) forces:
  - IDLE, lfsr=SEED, cnt=0, phase_out=0;
  - sym_strobe=0, underrun=0, ext_ready=0, busy=0.
- load=1 in any state (including RUN) at edge E0:
  - lfsr = (seed_in==0 ? SEED : seed_in), phase_out=0, cnt=0;
  - underrun=0, latch src_sel, state = RUN.
- load has priority over enable and over any symbol boundary on the same edge.
- LFSR step: bit = lfsr[LFSR_W-1], then lfsr = {lfsr[LFSR_W-2:0], feedback}.
  - DBPSK takes one step per symbol.
  - DQPSK takes two steps in the same cycle: b1 comes from the first step, b0 from the second.
- Boundary: state RUN, enable=1 and cnt==0. At a boundary the core:
  - fetches the symbol bits;
  - updates phase_out;
  - pulses sym_strobe;
  - reloads cnt = SPS-1.
- In RUN with enable=1 and cnt≠0, cnt decrements by 1.
- Phase update, mod 4:
  - DBPSK: bit 0 → +0, bit 1 → +2.
  - DQPSK (Gray): 00 → +0, 01 → +1, 11 → +2, 10 → +3.
- External source:
  - ext_ready = busy & enable & (cnt==0) & src_sel_latched. It is combinational from state.
  - Transfer happens when ext_valid & ext_ready.
  - If the boundary occurs with ext_valid=0: phase_out holds, sym_strobe stays 0, underrun is set, and cnt still reloads to SPS-1.
  - The LFSR does not step in external mode.
- enable=0 holds cnt, lfsr, phase_out and state. sym_strobe reads 0.
- IDLE: outputs hold their reset values, and load is the only exit.

## Timing

- First boundary is the edge after E0 (E1). phase_out and sym_strobe are valid after E1.
- Later boundaries fall every SPS enabled edges. With SPS=1, every enabled edge is a boundary.
- phase_out, xor_result, sym_strobe, busy and underrun are registered outputs. ext_ready is not.
- A reset or load mid-symbol discards the partial symbol immediately. There is no drain.
- Pausing enable stretches the current symbol by the number of paused cycles.

## Test plan

- Reset hold, then load with seed_in=0, MODE=0, SPS=4 → seed = 7'h01:
  - sym_strobe at E1, E1+4, …;
  - phase_out = 0 for the first 6 symbols, 2 on the 7th.
- MODE=1, seed_in=7'b1100000 → first dibit 11, so phase_out=2 after E1 and lfsr=7'b0000001.
- src_sel=1, ext_data sequence 01, 01, 11 with ext_valid ready at each boundary, DQPSK → phase_out 1, 2, 0.
- External source with ext_valid dropped for one boundary:
  - phase_out unchanged for that slot;
  - no strobe;
  - underrun=1 and stays 1 until the next load.
- enable low for 3 cycles mid-symbol (SPS=4) → next boundary arrives 3 cycles late and phase_out is unchanged.
- load in RUN at cnt=2 → phase_out=0 and cnt=0 immediately; boundary on the following edge. A reset mid-RUN returns all outputs to reset values.
